// File: rtl/led_frame_scanner_if.sv
// led_frame_scanner_if: frame-buffer read port, receiver bank indication and LED pixel stream.
// master = scanner side (drives reads and pixels); slave = buffer/LED-driver side.
// wr_bank is a level from the receiver clock domain and is synchronised inside the scanner.
interface led_frame_scanner_if #(
   parameter int ADDR_W = 9
);
   logic              wr_bank;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_ce1_n;
   logic              rd_ce2_n;
   logic [15:0]       rd_data1;
   logic [15:0]       rd_data2;
   logic [15:0]       out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_sof;
   logic              out_eol;
   logic [4:0]        row_idx;

   modport master (
      input  wr_bank, rd_data1, rd_data2, out_ready,
      output rd_addr, rd_ce1_n, rd_ce2_n, out_data, out_valid, out_sof, out_eol, row_idx
   );

   modport slave (
      output wr_bank, rd_data1, rd_data2, out_ready,
      input  rd_addr, rd_ce1_n, rd_ce2_n, out_data, out_valid, out_sof, out_eol, row_idx
   );
endinterface

// File: rtl/led_frame_scanner.sv
// led_frame_scanner: re-scans the latest completed ping-pong bank row by row as 16b pixel words.
// Latency: LOAD to first out_valid is 3 clks; 1 word/clk within a row while out_ready stays high.
// Backpressure: out_* hold until accepted; a 2-entry skid FIFO absorbs reads already in flight.
// Build option: define LED_BLANK_EN to insert BLANK_CYC idle clks after every row.
module led_frame_scanner #(
   parameter int ADDR_W        = 9,
   parameter int WORDS_PER_ROW = 16,
   parameter int ROWS          = 32,
   parameter int BLANK_CYC     = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   led_frame_scanner_if.master   bus
);

`ifdef LED_BLANK_EN
   localparam logic BLANK_EN = 1'b1;
`else
   localparam logic BLANK_EN = 1'b0;
`endif

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] SCAN  = 2'd2;
   localparam logic [1:0] BLANK = 2'd3;

   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(ROWS * WORDS_PER_ROW - 1);
   localparam logic [ADDR_W-1:0] ROW_WORDS  = ADDR_W'(WORDS_PER_ROW);
   localparam logic [ADDR_W-1:0] ROW_LAST   = ADDR_W'(WORDS_PER_ROW - 1);
   localparam logic [7:0]        BLANK_LAST = 8'(BLANK_CYC - 1);

   logic              sync_meta, sync_q, sync_d;
   logic              pend_bank, pending;
   logic              disp_bank, have_frame;
   logic [1:0]        state;
   logic [7:0]        blank_cnt;
   logic              frame_end_q;
   logic [ADDR_W-1:0] fetch_addr;
   logic              fetch_done;
   logic              inflight;
   logic [15:0]       fifo0, fifo1;
   logic [1:0]        fcnt;
   logic [15:0]       out_data_q;
   logic              out_valid_q;
   logic [ADDR_W-1:0] out_cnt;

   logic        sync_edge, xfer, at_eol, at_end, row_end_blank, blank_last;
   logic        load_ok, issue, bypass, pop, push;
   logic [15:0] rd_q;

   // Handshake, position decode and read/skid-FIFO steering.
   always_comb begin
      sync_edge     = sync_q ^ sync_d;
      xfer          = out_valid_q && bus.out_ready;
      at_eol        = (out_cnt % ROW_WORDS) == ROW_LAST;
      at_end        = out_cnt == LAST_ADDR;
      row_end_blank = BLANK_EN && xfer && at_eol;
      blank_last    = (state == BLANK) && (blank_cnt == BLANK_LAST);
      // The output register may refill in SCAN (except on a row end that enters BLANK) and in
      // the last BLANK clk, so the gap after a row is exactly BLANK_CYC clks.
      load_ok       = ((state == SCAN && !row_end_blank) || (blank_last && !frame_end_q))
                      && (!out_valid_q || xfer);
      issue         = (state == SCAN) && have_frame && !fetch_done
                      && ((fcnt == 2'd0) || (fcnt == 2'd1 && !inflight));
      rd_q          = disp_bank ? bus.rd_data2 : bus.rd_data1;
      bypass        = load_ok && (fcnt == 2'd0) && inflight;
      pop           = load_ok && (fcnt != 2'd0);
      push          = inflight && !bypass;
   end

   assign bus.rd_addr   = fetch_addr;
   assign bus.rd_ce1_n  = !(issue && !disp_bank);
   assign bus.rd_ce2_n  = !(issue && disp_bank);
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sof   = out_valid_q && (out_cnt == '0);
   assign bus.out_eol   = out_valid_q && at_eol;
   assign bus.row_idx   = 5'(out_cnt / ROW_WORDS);

   // Synchronise wr_bank; any edge means the other bank was just completed (latest edge wins).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_meta <= 1'b0;
         sync_q    <= 1'b0;
         sync_d    <= 1'b0;
         pend_bank <= 1'b0;
         pending   <= 1'b0;
      end else begin
         sync_meta <= bus.wr_bank;
         sync_q    <= sync_meta;
         sync_d    <= sync_q;
         if (sync_edge) begin
            pend_bank <= ~sync_q;
            pending   <= 1'b1;
         end else if (state == LOAD) begin
            pending   <= 1'b0;
         end
      end
   end

   // Frame sequencing: bank swaps happen only at frame boundaries.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         have_frame  <= 1'b0;
         disp_bank   <= 1'b0;
         blank_cnt   <= '0;
         frame_end_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               have_frame <= 1'b0;
               if (pending) state <= LOAD;
            end
            LOAD: begin
               disp_bank  <= pend_bank;
               have_frame <= 1'b1;
               state      <= SCAN;
            end
            SCAN: begin
               if (row_end_blank) begin
                  state       <= BLANK;
                  blank_cnt   <= '0;
                  frame_end_q <= at_end;
               end else if (xfer && at_end) begin
                  state <= pending ? LOAD : SCAN;
               end
            end
            default: begin
               blank_cnt <= blank_cnt + 8'd1;
               if (blank_last) begin
                  frame_end_q <= 1'b0;
                  state       <= (frame_end_q && pending) ? LOAD : SCAN;
               end
            end
         endcase
      end
   end

   // Read address generation; stops at the last word until the frame has been fully accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_addr <= '0;
         fetch_done <= 1'b0;
         inflight   <= 1'b0;
      end else begin
         inflight <= issue;
         if (state == LOAD || (xfer && at_end)) begin
            fetch_addr <= '0;
            fetch_done <= 1'b0;
         end else if (issue) begin
            if (fetch_addr == LAST_ADDR) fetch_done <= 1'b1;
            else                         fetch_addr <= fetch_addr + 1'b1;
         end
      end
   end

   // Skid FIFO: holds returning read data the output register cannot take yet.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fifo0 <= '0;
         fifo1 <= '0;
         fcnt  <= 2'd0;
      end else begin
         case ({pop, push})
            2'b10: begin
               fifo0 <= fifo1;
               fcnt  <= fcnt - 2'd1;
            end
            2'b01: begin
               if (fcnt == 2'd0) fifo0 <= rd_q;
               else              fifo1 <= rd_q;
               fcnt <= fcnt + 2'd1;
            end
            2'b11: begin
               if (fcnt == 2'd1) begin
                  fifo0 <= rd_q;
               end else begin
                  fifo0 <= fifo1;
                  fifo1 <= rd_q;
               end
            end
            default: ;
         endcase
      end
   end

   // Output register and word position; contents hold while valid and not accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_cnt     <= '0;
      end else begin
         if (state == LOAD)  out_cnt <= '0;
         else if (xfer)      out_cnt <= at_end ? '0 : out_cnt + 1'b1;
         if (load_ok) begin
            if (pop) begin
               out_data_q  <= fifo0;
               out_valid_q <= 1'b1;
            end else if (bypass) begin
               out_data_q  <= rd_q;
               out_valid_q <= 1'b1;
            end else begin
               out_valid_q <= 1'b0;
            end
         end else if (xfer) begin
            out_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_led_frame_scanner.sv
// tb_led_frame_scanner: drives led_frame_scanner with a two-bank buffer model and random ready.
// Expected pixel streams come from a frame-level model (bank, word index, pending swap).
// One task per scenario; ends with a single summary line.
module tb_led_frame_scanner;
   localparam int ADDR_W    = 9;
   localparam int WPR       = 16;
   localparam int ROWS      = 32;
   localparam int BLANK_CYC = 4;
   localparam int FRAME     = 512;
`ifdef LED_BLANK_EN
   localparam int ROW_GAP = BLANK_CYC + 1;
`else
   localparam int ROW_GAP = 1;
`endif

   typedef struct packed {
      logic [15:0] data;
      logic        sof;
      logic        eol;
      logic [4:0]  row;
   } word_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] rdata1_r = '0;
   logic [15:0] rdata2_r = '0;
   logic        rand_ready = 1'b0;
   logic [15:0] mem0 [FRAME];
   logic [15:0] mem1 [FRAME];

   int checks = 0;
   int errors = 0;
   int cyc = 0, ce1_low = 0, ce2_low = 0, both_low = 0, valid_cnt = 0, hold_viol = 0;
   word_t got_q[$];
   int    got_cyc[$];
   word_t prev_w;
   logic  prev_stall = 1'b0;

   // frame-level reference model
   bit m_bank = 1'b0, m_pend = 1'b0, m_pending = 1'b0;
   int m_idx = 0;

   led_frame_scanner_if #(.ADDR_W(ADDR_W)) bus ();

   led_frame_scanner #(
      .ADDR_W(ADDR_W), .WORDS_PER_ROW(WPR), .ROWS(ROWS), .BLANK_CYC(BLANK_CYC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   assign bus.rd_data1 = rdata1_r;
   assign bus.rd_data2 = rdata2_r;

   initial forever #5 clk = ~clk;

   // synchronous two-bank buffer: data valid one clk after its chip enable
   always @(posedge clk) begin
      if (!bus.rd_ce1_n) rdata1_r <= mem0[bus.rd_addr];
      if (!bus.rd_ce2_n) rdata2_r <= mem1[bus.rd_addr];
   end

   // LED driver ready: held high, or a fresh coin flip every clk
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // monitor on the falling edge: collect accepted words, count enables, watch output hold
   initial begin
      word_t w;
      forever begin
         @(negedge clk);
         cyc++;
         if (!bus.rd_ce1_n) ce1_low++;
         if (!bus.rd_ce2_n) ce2_low++;
         if (!bus.rd_ce1_n && !bus.rd_ce2_n) both_low++;
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (bus.out_valid) valid_cnt++;
            w = '{data: bus.out_data, sof: bus.out_sof, eol: bus.out_eol, row: bus.row_idx};
            if (prev_stall && (!bus.out_valid || w !== prev_w)) hold_viol++;
            if (bus.out_valid && bus.out_ready) begin
               got_q.push_back(w);
               got_cyc.push_back(cyc);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_w     = w;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   // next expected word of the stream: a completed bank is shown from the next frame start
   task automatic model_next(output word_t e, output int idx);
      if (m_idx == 0 && m_pending) begin
         m_bank    = m_pend;
         m_pending = 1'b0;
      end
      idx    = m_idx;
      e.data = m_bank ? (16'h8000 | 16'(m_idx)) : 16'(m_idx);
      e.sof  = (m_idx == 0);
      e.eol  = (m_idx % WPR) == WPR - 1;
      e.row  = 5'(m_idx / WPR);
      m_idx  = (m_idx + 1) % FRAME;
   endtask

   // receiver finishes the bank it was writing and moves to the other one
   task automatic toggle_wr();
      @(posedge clk);
      #1;
      m_pend       = bus.wr_bank;
      m_pending    = 1'b1;
      bus.wr_bank  = ~bus.wr_bank;
   endtask

   task automatic get_word(output word_t w, output int c, output bit ok);
      ok = 1'b0;
      w  = '0;
      c  = 0;
      for (int i = 0; i < 400; i++) begin
         if (got_q.size() > 0) begin
            w  = got_q.pop_front();
            c  = got_cyc.pop_front();
            ok = 1'b1;
            break;
         end
         @(negedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.out_valid, bus.rd_ce1_n, bus.rd_ce2_n} !== 3'b011) begin
         errors++;
         $display("FAIL reset_ctrl valid/ce1_n/ce2_n got %b want 011",
                  {bus.out_valid, bus.rd_ce1_n, bus.rd_ce2_n});
      end
      checks++;
      if (bus.rd_addr !== 9'd0) begin
         errors++;
         $display("FAIL reset_addr got %0d want 0", bus.rd_addr);
      end
      checks++;
      if ({bus.out_data, bus.out_sof, bus.out_eol, bus.row_idx} !== 23'd0) begin
         errors++;
         $display("FAIL reset_out data=%h sof=%b eol=%b row=%0d want all 0",
                  bus.out_data, bus.out_sof, bus.out_eol, bus.row_idx);
      end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_idle();
      valid_cnt = 0; ce1_low = 0; ce2_low = 0;
      repeat (2000) @(posedge clk);
      #1;
      checks++;
      if (valid_cnt !== 0) begin
         errors++;
         $display("FAIL idle_valid got %0d valid clks want 0", valid_cnt);
      end
      checks++;
      if (ce1_low !== 0 || ce2_low !== 0) begin
         errors++;
         $display("FAIL idle_ce got ce1 %0d ce2 %0d low clks want 0 0", ce1_low, ce2_low);
      end
   endtask

   task automatic test_first_frame();
      word_t w, e;
      int c, pc, idx, gap;
      bit ok;
      pc = 0;
      got_q.delete(); got_cyc.delete();
      ce2_low = 0;
      toggle_wr();
      for (int k = 0; k < FRAME; k++) begin
         get_word(w, c, ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL first_frame timeout at word %0d", k);
            return;
         end
         model_next(e, idx);
         checks++;
         if (w !== e) begin
            errors++;
            $display("FAIL first_frame word %0d got %h sof%b eol%b row%0d want %h sof%b eol%b row%0d",
                     k, w.data, w.sof, w.eol, w.row, e.data, e.sof, e.eol, e.row);
         end
         if (!e.sof) begin
            gap = (idx % WPR == 0) ? ROW_GAP : 1;
            checks++;
            if (c - pc !== gap) begin
               errors++;
               $display("FAIL first_frame gap before word %0d got %0d want %0d", idx, c - pc, gap);
            end
         end
         pc = c;
      end
      checks++;
      if (ce2_low !== 0) begin
         errors++;
         $display("FAIL first_frame ce2 got %0d low clks want 0", ce2_low);
      end
   endtask

   task automatic test_repeat();
      word_t w, e;
      int c, pc, idx, gap;
      bit ok;
      pc = 0;
      ce1_low = 0; ce2_low = 0;
      for (int k = 0; k < FRAME; k++) begin
         get_word(w, c, ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL repeat timeout at word %0d", k);
            return;
         end
         model_next(e, idx);
         checks++;
         if (w !== e) begin
            errors++;
            $display("FAIL repeat word %0d got %h sof%b eol%b row%0d want %h sof%b eol%b row%0d",
                     k, w.data, w.sof, w.eol, w.row, e.data, e.sof, e.eol, e.row);
         end
         if (!e.sof) begin
            gap = (idx % WPR == 0) ? ROW_GAP : 1;
            checks++;
            if (c - pc !== gap) begin
               errors++;
               $display("FAIL repeat gap before word %0d got %0d want %0d", idx, c - pc, gap);
            end
         end
         pc = c;
      end
      checks++;
      if (ce2_low !== 0 || ce1_low == 0) begin
         errors++;
         $display("FAIL repeat_ce got ce1 %0d ce2 %0d low clks want ce1>0 ce2 0", ce1_low, ce2_low);
      end
   endtask

   task automatic test_swap();
      word_t w, e;
      int c, idx;
      bit ok;
      for (int k = 0; k < 2 * FRAME; k++) begin
         get_word(w, c, ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL swap timeout at word %0d", k);
            return;
         end
         model_next(e, idx);
         checks++;
         if (w !== e) begin
            errors++;
            $display("FAIL swap word %0d got %h sof%b eol%b row%0d want %h sof%b eol%b row%0d",
                     k, w.data, w.sof, w.eol, w.row, e.data, e.sof, e.eol, e.row);
         end
         if (k == 100) toggle_wr();
         if (k == FRAME) begin
            checks++;
            if (w.data !== 16'h8000 || w.sof !== 1'b1) begin
               errors++;
               $display("FAIL swap_first got %h sof%b want 8000 sof1", w.data, w.sof);
            end
         end
         if (k == FRAME + 10) begin
            ce1_low = 0; ce2_low = 0;
         end
         if (k == FRAME + 500) begin
            checks++;
            if (ce1_low !== 0 || ce2_low == 0) begin
               errors++;
               $display("FAIL swap_ce got ce1 %0d ce2 %0d low clks want ce1 0 ce2>0", ce1_low, ce2_low);
            end
         end
      end
      checks++;
      if (both_low !== 0) begin
         errors++;
         $display("FAIL ce_exclusive got %0d clks with both enables low want 0", both_low);
      end
   endtask

   task automatic test_random_ready();
      word_t w, e;
      int c, idx;
      bit ok;
      hold_viol = 0;
      rand_ready = 1'b1;
      for (int k = 0; k < 600; k++) begin
         get_word(w, c, ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL random_ready timeout at word %0d", k);
            rand_ready = 1'b0;
            return;
         end
         model_next(e, idx);
         checks++;
         if (w !== e) begin
            errors++;
            $display("FAIL random_ready word %0d got %h sof%b eol%b row%0d want %h sof%b eol%b row%0d",
                     k, w.data, w.sof, w.eol, w.row, e.data, e.sof, e.eol, e.row);
         end
      end
      rand_ready = 1'b0;
      checks++;
      if (hold_viol !== 0) begin
         errors++;
         $display("FAIL random_ready_hold got %0d changes while stalled want 0", hold_viol);
      end
   endtask

   task automatic test_reset_mid();
      word_t w, e;
      int c, idx;
      bit ok;
      idx = -1;
      for (int k = 0; k < 2 * FRAME && idx != 300; k++) begin
         get_word(w, c, ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL reset_mid timeout at word %0d", k);
            return;
         end
         model_next(e, idx);
         checks++;
         if (w !== e) begin
            errors++;
            $display("FAIL reset_mid word %0d got %h want %h", k, w.data, e.data);
         end
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int t = 0; t < 2; t++) begin
         #1;
         checks++;
         if ({bus.out_valid, bus.rd_ce1_n, bus.rd_ce2_n, bus.rd_addr} !== {3'b011, 9'd0}) begin
            errors++;
            $display("FAIL reset_mid_ctrl got valid%b ce1_n%b ce2_n%b addr%0d want 0 1 1 0",
                     bus.out_valid, bus.rd_ce1_n, bus.rd_ce2_n, bus.rd_addr);
         end
         checks++;
         if ({bus.out_data, bus.out_sof, bus.out_eol, bus.row_idx} !== 23'd0) begin
            errors++;
            $display("FAIL reset_mid_out data=%h sof=%b eol=%b row=%0d want all 0",
                     bus.out_data, bus.out_sof, bus.out_eol, bus.row_idx);
         end
         @(posedge clk);
      end
      #1;
      rst = 1'b0;
      got_q.delete(); got_cyc.delete();
      m_idx = 0; m_pending = 1'b0;
      valid_cnt = 0; ce1_low = 0; ce2_low = 0;
      repeat (200) @(posedge clk);
      #1;
      checks++;
      if (valid_cnt !== 0 || ce1_low !== 0 || ce2_low !== 0) begin
         errors++;
         $display("FAIL reset_mid_quiet got valid %0d ce1 %0d ce2 %0d want 0 0 0",
                  valid_cnt, ce1_low, ce2_low);
      end
      toggle_wr();
      for (int k = 0; k < 40; k++) begin
         get_word(w, c, ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL resume timeout at word %0d", k);
            return;
         end
         model_next(e, idx);
         checks++;
         if (w !== e) begin
            errors++;
            $display("FAIL resume word %0d got %h sof%b eol%b row%0d want %h sof%b eol%b row%0d",
                     k, w.data, w.sof, w.eol, w.row, e.data, e.sof, e.eol, e.row);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < FRAME; i++) begin
         mem0[i] = 16'(i);
         mem1[i] = 16'h8000 | 16'(i);
      end
      bus.wr_bank = 1'b0;
      test_reset();
      test_idle();
      test_first_frame();
      test_repeat();
      test_swap();
      test_random_ready();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
